// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single-port synchronous display RAM between the 6502 bus and
//   the video character-fetch path. Video fetches have strict priority and
//   issue one per cycle; the CPU is served in idle slots through a
//   request/acknowledge handshake. A wait counter flags CPU starvation.
//
// Ports
//   clk, n_reset                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata             CPU request (level, held until ack)
//   cpu_ack, cpu_rdata                one-cycle completion pulse, read data (held)
//   vid_req, vid_addr                 one-cycle fetch strobe and address
//   vid_valid, vid_rdata              one-cycle fetch data pulse and data
//   ram_addr/we/wdata, ram_rdata      registered RAM controls, RAM read data
//   cpu_starved                       sticky starvation flag
module vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_starved
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_ISSUED,
        C_ACK
    } cpu_state_t;

    cpu_state_t        r_state;
    cpu_state_t        w_state_next;

    logic              w_cpu_elig;
    logic              w_cpu_grant;

    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_cpu_we_lat;

    logic              r_tag1_vid;
    logic              r_tag1_cpu;
    logic              r_tag2_vid;
    logic              r_tag2_cpu;

    logic              r_vid_valid;
    logic [DATA_W-1:0] r_vid_rdata;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_starved;

    // C_ACK is excluded so a request still held high during its ack cycle
    // is not issued a second time.
    assign w_cpu_elig  = cpu_req && ((r_state == C_IDLE) || (r_state == C_WAIT)) && !r_cpu_ack;
    assign w_cpu_grant = !vid_req && w_cpu_elig;

    // CPU state register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CPU next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (cpu_req) begin
                    w_state_next = w_cpu_grant ? C_ISSUED : C_WAIT;
                end
            end
            C_WAIT: begin
                if (w_cpu_grant) begin
                    w_state_next = C_ISSUED;
                end
            end
            C_ISSUED: begin
                if (r_tag2_cpu) begin
                    w_state_next = C_ACK;
                end
            end
            C_ACK: begin
                w_state_next = C_IDLE;
            end
            default: begin
                w_state_next = C_IDLE;
            end
        endcase
    end

    // Wait counter: clearing on entry to C_ISSUED wins over the increment
    // of the final C_WAIT cycle.
    always_comb begin
        w_cnt_next = r_cnt;
        if ((w_state_next == C_ISSUED) && (r_state != C_ISSUED)) begin
            w_cnt_next = '0;
        end else if ((r_state == C_WAIT) && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt     <= '0;
            r_starved <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == CNT_MAX) begin
                r_starved <= 1'b1;
            end
        end
    end

    // Issue stage, tag pipeline and read-data capture
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= '0;
            r_cpu_we_lat <= 1'b0;
            r_tag1_vid   <= 1'b0;
            r_tag1_cpu   <= 1'b0;
            r_tag2_vid   <= 1'b0;
            r_tag2_cpu   <= 1'b0;
            r_vid_valid  <= 1'b0;
            r_vid_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_ram_we <= 1'b0;
            if (vid_req) begin
                r_ram_addr <= vid_addr;
            end else if (w_cpu_grant) begin
                r_ram_addr   <= cpu_addr;
                r_ram_we     <= cpu_we;
                r_ram_wdata  <= cpu_wdata;
                r_cpu_we_lat <= cpu_we;
            end

            r_tag1_vid <= vid_req;
            r_tag1_cpu <= w_cpu_grant;
            r_tag2_vid <= r_tag1_vid;
            r_tag2_cpu <= r_tag1_cpu;

            r_vid_valid <= r_tag2_vid;
            if (r_tag2_vid) begin
                r_vid_rdata <= ram_rdata;
            end

            // Only one CPU access is ever in flight, so the latched
            // direction still belongs to the tag reaching stage 2.
            r_cpu_ack <= r_tag2_cpu;
            if (r_tag2_cpu && !r_cpu_we_lat) begin
                r_cpu_rdata <= ram_rdata;
            end
        end
    end

    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = r_cpu_rdata;
    assign vid_valid   = r_vid_valid;
    assign vid_rdata   = r_vid_rdata;
    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_wdata   = r_ram_wdata;
    assign cpu_starved = r_starved;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port synchronous display RAM between the 6502 bus (CPU reads and writes of screen memory) and the character-fetch path of the video generator inside the uk101 core. Video fetches have strict priority and are fully pipelined, one per cycle. The CPU uses a request/acknowledge handshake and is served in idle slots. A waiting-time monitor flags CPU starvation for debug and status.

## Interface
Parameters:
- ADDR_W, 11, RAM address width (2 KiB, 64x32 characters)
- DATA_W, 8, RAM data width
- STARVE_LIMIT, 64, number of CPU wait cycles after which `cpu_starved` is set

Ports:
- clk  in  1  system clock; every register is on its rising edge
- n_reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; level, held until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read; stable while `cpu_req` is high
- cpu_addr  in  ADDR_W  CPU address; stable while `cpu_req` is high
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid while `cpu_ack` is high, held until the next CPU read completes
- vid_req  in  1  one-cycle fetch strobe; may be high on consecutive cycles
- vid_addr  in  ADDR_W  fetch address, sampled with `vid_req`
- vid_valid  out  1  one-cycle pulse marking fetch data
- vid_rdata  out  DATA_W  fetch data; valid while `vid_valid` is high
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, one cycle after the address is presented
- cpu_starved  out  1  sticky; set when the CPU wait count reaches STARVE_LIMIT

## Operation
- Issue stage (S0): the arbiter makes one decision per edge.
  - If `vid_req` is high: video is granted. `ram_addr` <= `vid_addr`, `ram_we` <= 0.
  - Otherwise, if the CPU is eligible: the CPU is granted. `ram_addr` <= `cpu_addr`, `ram_we` <= `cpu_we`, `ram_wdata` <= `cpu_wdata`.
  - Otherwise: `ram_we` <= 0. `ram_addr` holds its previous value.
- The CPU is eligible when `cpu_req` is high, the CPU FSM is in C_IDLE or C_WAIT, and `cpu_ack` is low.
- Tag pipeline: a two-stage shift of {vid, cpu} grant tags that follows S0.
  - Stage 1 marks the cycle in which the RAM samples the address.
  - Stage 2 captures `ram_rdata`:
    - vid tag: `vid_rdata` <= `ram_rdata`, `vid_valid` <= 1.
    - cpu tag: `cpu_ack` <= 1; on a read, `cpu_rdata` <= `ram_rdata`.
- CPU FSM:
  - C_IDLE: `cpu_req` high and not granted -> C_WAIT. `cpu_req` high and granted -> C_ISSUED.
  - C_WAIT: granted -> C_ISSUED.
  - C_ISSUED: waits for the stage-2 tag, then -> C_ACK with `cpu_ack` = 1.
  - C_ACK: -> C_IDLE unconditionally. No grant is made in this cycle, which blocks re-issue of a request the master has not yet dropped.
- A CPU write is acknowledged with the same latency as a read. `cpu_rdata` is unchanged by writes.
- Wait counter:
  - Width is clog2(STARVE_LIMIT+1). It increments, saturating, on each cycle spent in C_WAIT, and clears on entry to C_ISSUED.
  - `cpu_starved` is set when the counter reaches STARVE_LIMIT. Only `n_reset` clears it.
- A `vid_req` and an eligible `cpu_req` in the same cycle: video wins and the CPU waits. There is no fairness override, because video timing is hard.

## Timing
- Reset values: `cpu_ack` = 0, `vid_valid` = 0, `cpu_rdata` = 0, `vid_rdata` = 0, `ram_addr` = 0, `ram_we` = 0, `ram_wdata` = 0, `cpu_starved` = 0. FSM in C_IDLE, tags cleared, counter = 0.
- Reset mid-operation: in-flight tags are discarded and no ack or valid is produced for them. The CPU must re-request after reset is released.
- Video latency: `vid_req` sampled at edge E -> `vid_valid` high in the cycle after edge E+2.
- Video throughput: one fetch per cycle, in order, with no bubbles.
- Uncontended CPU latency: `cpu_req` sampled at E -> `cpu_ack` high in the cycle after E+2.
- Minimum spacing between two CPU accesses: 4 cycles.
- `ram_we` is high for exactly one cycle per CPU write and never high for a video grant.

## Test plan
- Reset values: hold `n_reset` low, drive random inputs -> all outputs at their reset values; the RAM model shows no write.
- Video stream: `vid_req` on 8 consecutive cycles, addresses 0x000-0x007, RAM preloaded so data = address -> `vid_valid` on 8 consecutive cycles starting 3 cycles later, data 0x00-0x07 in order.
- CPU write then read: write 0xA5 to 0x3C0, then read 0x3C0 with no video traffic -> first `cpu_ack` 3 cycles after request; read returns `cpu_rdata` = 0xA5; exactly one `ram_we` pulse observed.
- Collision: `cpu_req` (read 0x010) and a 5-cycle `vid_req` burst start together -> all 5 video fetches complete first; `cpu_ack` arrives 5 cycles later than uncontended; video data uncorrupted.
- Starvation: hold `vid_req` high for 70 cycles with `cpu_req` pending, STARVE_LIMIT = 64 -> `cpu_starved` rises after 64 wait cycles and stays high after the CPU access completes.
- Reset mid-access: assert `n_reset` low one cycle after a CPU grant -> no `cpu_ack`; a fresh request after release completes normally.
